// File: rtl/regfile_dump_reader_if.sv
// Dump stream channel of regfile_dump_reader.
// Carries one register word and its address under a valid/ready handshake.
//   dump_valid : producer holds a word on dump_data/dump_addr
//   dump_ready : consumer accepts the word on this cycle's rising edge
//   dump_data  : register value (B bits)
//   dump_addr  : register address of dump_data (N bits)
// master = producer (the dump reader), slave = consumer.
interface regfile_dump_reader_if #(
  parameter int unsigned B = 32,
  parameter int unsigned N = 5
);
  logic         dump_valid;
  logic         dump_ready;
  logic [B-1:0] dump_data;
  logic [N-1:0] dump_addr;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_addr,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_addr,
    output dump_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine.
// On a start pulse, walks the address range first_addr..last_addr (inclusive,
// wrapping modulo 2^N) through one combinational register-file read port. It
// streams each word with its address on the dump interface at one word per
// cycle while the consumer is ready.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   start      : request, sampled only when idle
//   first_addr : first address of the range, captured with start
//   last_addr  : last address of the range (inclusive), captured with start
//   r_addr     : registered read address to the register file
//   r_data     : combinational read data for r_addr
//   dump       : valid/ready word stream (master side)
//   busy       : high from the load cycle until the final handshake
//   done       : one-cycle pulse after the final word is accepted
module regfile_dump_reader #(
  parameter int unsigned B = 32,
  parameter int unsigned N = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          first_addr,
  input  logic [N-1:0]          last_addr,
  output logic [N-1:0]          r_addr,
  input  logic [B-1:0]          r_data,
  regfile_dump_reader_if.master dump,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] last_q, last_d;
  logic         valid_q, valid_d;
  logic [B-1:0] data_q, data_d;
  logic [N-1:0] addr_q, addr_d;
  logic         done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = first_addr;
          last_d  = last_addr;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // r_addr already equals idx, so r_data is the first word.
        data_d  = r_data;
        addr_d  = idx_q;
        valid_d = 1'b1;
        idx_d   = idx_q + N'(1);
        state_d = StSend;
      end
      StSend: begin
        if (dump.dump_ready) begin
          // Compare against the word being accepted rather than idx, so a
          // full 2^N range (last == first-1) still terminates correctly.
          if (addr_q == last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            // r_addr is one ahead, giving back-to-back words with no bubble.
            data_d = r_data;
            addr_d = idx_q;
            idx_d  = idx_q + N'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign r_addr          = idx_q;
  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign dump.dump_valid = valid_q;
  assign dump.dump_data  = data_q;
  assign dump.dump_addr  = addr_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed testbench for regfile_dump_reader with a behavioural 32x32
// register file. Inputs are driven and outputs sampled on the falling edge.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic        busy;
  logic        done;

  regfile_dump_reader_if #(.B(32), .N(5)) dif ();

  regfile_dump_reader #(.B(32), .N(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .dump       (dif),
    .busy       (busy),
    .done       (done)
  );

  // Register file model: combinational read, clocked write.
  logic [31:0] regs [32];
  logic        preload;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  assign r_data = regs[r_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i * 3);
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Results of the most recent run_dump.
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int          done_cnt;
  int          valid_edge;
  int          done_edge;
  int          hold_err;
  int          overlap_err;
  logic        busy_at_done;
  bit          timed_out;

  // Optional write injected on the edge that captures cw_addr.
  bit          cw_en;
  logic [4:0]  cw_addr;
  logic [31:0] cw_data;

  // Runs one dump and records what the stream produced. Edge numbering:
  // E0 (start sampled) is edge 1, so dump_valid should first appear at 2.
  // mode 0: ready always 1; mode 1: ready pattern 1,0,0 per valid cycle.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input int budget);
    int          cyc;
    int          vcnt;
    int          after;
    bit          prev_stall;
    logic [31:0] pd;
    logic [4:0]  pa;
    got_addr.delete();
    got_data.delete();
    done_cnt = 0; valid_edge = -1; done_edge = -1; hold_err = 0; overlap_err = 0;
    busy_at_done = 1'b1; timed_out = 1'b0;
    vcnt = 0; after = -1; prev_stall = 1'b0; pd = '0; pa = '0;
    first_addr = f; last_addr = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (after != 0) begin
      if (cyc > budget) begin
        timed_out = 1'b1;
        break;
      end
      if (dif.dump_valid && valid_edge < 0) valid_edge = cyc;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge    = cyc;
          busy_at_done = busy;
          after        = 3;
        end
        if (dif.dump_valid) overlap_err++;
      end
      if (prev_stall && (!dif.dump_valid || dif.dump_data !== pd || dif.dump_addr !== pa))
        hold_err++;
      we = 1'b0;
      if (cw_en && busy && r_addr == cw_addr) begin
        we = 1'b1; wa = cw_addr; wd = cw_data; cw_en = 1'b0;
      end
      if (dif.dump_valid) begin
        dif.dump_ready = (mode == 0) ? 1'b1 : ((vcnt % 3) == 0);
        vcnt++;
      end else begin
        dif.dump_ready = 1'b1;
      end
      if (dif.dump_valid && dif.dump_ready) begin
        got_addr.push_back(dif.dump_addr);
        got_data.push_back(dif.dump_data);
      end
      prev_stall = dif.dump_valid && !dif.dump_ready;
      pd = dif.dump_data;
      pa = dif.dump_addr;
      if (after > 0) after--;
      @(negedge clk);
      cyc++;
    end
    we = 1'b0;
    dif.dump_ready = 1'b1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (r_addr !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: r_addr=%0d busy=%b done=%b, required 0 0 0", r_addr, busy, done);
    end
    n_checks++;
    if (dif.dump_valid !== 1'b0 || dif.dump_data !== 32'd0 || dif.dump_addr !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_stream: valid=%b data=%h addr=%0d, required 0 0 0",
               dif.dump_valid, dif.dump_data, dif.dump_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep;
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    run_dump(5'd0, 5'd31, 0, 100);
    n_checks++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL sweep_timeout: no done within budget, required done");
    end
    n_checks++;
    if (got_addr.size() != 32) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d words, required 32", got_addr.size());
    end
    for (int i = 0; i < 32 && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== 5'(i) || got_data[i] !== 32'(i * 3)) begin
        n_fail++;
        $display("FAIL sweep_word%0d: got addr %0d data %h, required addr %0d data %h",
                 i, got_addr[i], got_data[i], i, i * 3);
      end
    end
    n_checks++;
    if (valid_edge != 2) begin
      n_fail++;
      $display("FAIL sweep_latency: valid at edge %0d, required 2", valid_edge);
    end
    n_checks++;
    if (done_edge != 34 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL sweep_done: edge %0d count %0d, required edge 34 count 1",
               done_edge, done_cnt);
    end
    n_checks++;
    if (busy_at_done !== 1'b0 || overlap_err != 0) begin
      n_fail++;
      $display("FAIL sweep_busy_done: busy %b overlap %0d, required 0 0",
               busy_at_done, overlap_err);
    end
  endtask

  task automatic test_concurrent_write;
    cw_en = 1'b1; cw_addr = 5'd10; cw_data = 32'h55;
    run_dump(5'd8, 5'd12, 0, 40);
    n_checks++;
    if (timed_out || got_data.size() != 5) begin
      n_fail++;
      $display("FAIL cw_count: got %0d words timeout %b, required 5 0", got_data.size(), timed_out);
    end else begin
      n_checks++;
      if (got_data[2] !== 32'd30 || got_addr[2] !== 5'd10) begin
        n_fail++;
        $display("FAIL cw_old_value: got addr %0d data %h, required addr 10 data 1e",
                 got_addr[2], got_data[2]);
      end
    end
    cw_en = 1'b0;
    run_dump(5'd8, 5'd12, 0, 40);
    n_checks++;
    if (got_data.size() != 5 || got_data[2] !== 32'h55 || got_data[0] !== 32'd24) begin
      n_fail++;
      $display("FAIL cw_new_value: got %0d words, word2 %h word0 %h, required 5 55 18",
               got_data.size(), got_data.size() > 2 ? got_data[2] : 32'hx,
               got_data.size() > 0 ? got_data[0] : 32'hx);
    end
  endtask

  task automatic test_single_word;
    write_reg(5'd7, 32'hDEADBEEF);
    run_dump(5'd7, 5'd7, 0, 20);
    n_checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 5'd7 || got_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_word: got %0d words first %0d/%h, required 1 word 7/deadbeef",
               got_addr.size(), got_addr.size() > 0 ? got_addr[0] : 5'hx,
               got_data.size() > 0 ? got_data[0] : 32'hx);
    end
    n_checks++;
    if (done_edge != 3 || done_cnt != 1 || timed_out) begin
      n_fail++;
      $display("FAIL single_done: edge %0d count %0d, required edge 3 count 1",
               done_edge, done_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [4:0]  exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
    exp_d = '{32'd90, 32'd93, 32'd0, 32'd3};
    run_dump(5'd30, 5'd1, 0, 20);
    n_checks++;
    if (got_addr.size() != 4 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d words %0d done, required 4 1", got_addr.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== exp_a[i] || got_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got %0d/%h, required %0d/%h",
                 i, got_addr[i], got_data[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_back_pressure;
    run_dump(5'd2, 5'd5, 1, 40);
    n_checks++;
    if (got_addr.size() != 4 || done_cnt != 1 || timed_out) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words %0d done, required 4 1", got_addr.size(), done_cnt);
    end
    for (int i = 0; i < 4 && i < got_addr.size(); i++) begin
      n_checks++;
      if (got_addr[i] !== 5'(i + 2) || got_data[i] !== 32'((i + 2) * 3)) begin
        n_fail++;
        $display("FAIL bp_word%0d: got %0d/%h, required %0d/%h",
                 i, got_addr[i], got_data[i], i + 2, (i + 2) * 3);
      end
    end
    n_checks++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable stall cycles, required 0", hold_err);
    end
  endtask

  task automatic test_mid_reset;
    int          n;
    int          k;
    int          dpulse;
    logic [4:0]  seen [$];
    n = 0; k = 0; dpulse = 0;
    dif.dump_ready = 1'b1;
    first_addr = 5'd0; last_addr = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 3 && k < 20) begin
      start = 1'b0;
      if (dif.dump_valid) begin
        seen.push_back(dif.dump_addr);
        n++;
        // Request while busy must be ignored.
        if (n == 1) begin
          start = 1'b1; first_addr = 5'd20; last_addr = 5'd20;
        end
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    n_checks++;
    if (seen.size() != 3 || seen[0] !== 5'd0 || seen[1] !== 5'd1 || seen[2] !== 5'd2) begin
      n_fail++;
      $display("FAIL mid_ignore_start: got %0d words, required addrs 0 1 2", seen.size());
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dif.dump_valid !== 1'b0 || dif.dump_data !== 32'd0 || dif.dump_addr !== 5'd0 ||
        r_addr !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: valid %b data %h addr %0d r_addr %0d busy %b done %b, required all 0",
               dif.dump_valid, dif.dump_data, dif.dump_addr, r_addr, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dpulse++;
      if (i == 1) rst = 1'b0;
    end
    n_checks++;
    if (dpulse != 0) begin
      n_fail++;
      $display("FAIL mid_no_done: %0d done pulses, required 0", dpulse);
    end
    run_dump(5'd0, 5'd0, 0, 20);
    n_checks++;
    if (got_addr.size() != 1 || got_addr[0] !== 5'd0 || got_data[0] !== 32'd0 ||
        done_cnt != 1 || valid_edge != 2) begin
      n_fail++;
      $display("FAIL mid_restart: got %0d words %0d done valid_edge %0d, required 1 1 2",
               got_addr.size(), done_cnt, valid_edge);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    start = 1'b0; first_addr = '0; last_addr = '0;
    preload = 1'b0; we = 1'b0; wa = '0; wd = '0;
    cw_en = 1'b0; cw_addr = '0; cw_data = '0;
    dif.dump_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_full_sweep();
    test_concurrent_write();
    test_single_word();
    test_wrap();
    test_back_pressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the CPU register file. On a start pulse it walks a contiguous (wrapping) range of register addresses through one register-file read port and streams each word with its address on a valid/ready interface. It feeds the debug/trace path and test benches that need a register snapshot without stopping the core. It sustains one word per cycle while the consumer is ready.

## Interface
- B, 32, data width; must match the register file word width.
- N, 5, address width; the register file holds 2^N words.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- first_addr  in  N  first address to read; captured with start.
- last_addr  in  N  last address to read (inclusive); captured with start.
- r_addr  out  N  read address to the register file port; registered.
- r_data  in  B  combinational read data returned for r_addr.
- dump_valid  out  1  dump_data/dump_addr hold a word.
- dump_ready  in  1  consumer accepts the word this cycle.
- dump_data  out  B  register value.
- dump_addr  out  N  address of dump_data.
- busy  out  1  high from LOAD until the final handshake.
- done  out  1  one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, LOAD, SEND.
- IDLE: busy=0, dump_valid=0. If start=1: idx<=first_addr, last<=last_addr, go to LOAD. start in any other state is ignored.
- LOAD (one cycle): dump_data<=r_data (value at r_addr=idx), dump_addr<=idx, dump_valid<=1, idx<=idx+1 mod 2^N, go to SEND.
- SEND, dump_valid=1, dump_ready=0: all outputs hold.
- SEND, handshake, dump_addr==last: dump_valid<=0, done<=1, idx<=0, go to IDLE.
- SEND, handshake, otherwise: capture r_data into dump_data, dump_addr<=idx, idx<=idx+1 mod 2^N, remain in SEND. This gives back-to-back words with no bubble.
- r_addr always equals idx. In SEND, r_addr already points to the next word.
- Range rules:
  - Addresses increment modulo 2^N.
  - first==last yields exactly one word.
  - last==first-1 (mod 2^N) yields all 2^N words.
  - Word count is ((last-first) mod 2^N)+1.
- Concurrent writes: a register-file write on the same edge that captures a word returns the pre-write value. A write that lands earlier appears in the stream. No snapshot atomicity is provided.
- done is registered, high for exactly one cycle, and never coincides with dump_valid.

## Timing
- Reset values: state IDLE, idx 0, r_addr 0, dump_valid 0, dump_data 0, dump_addr 0, busy 0, done 0.
- Start sampled at edge E0. The block is in LOAD after E0, with busy=1 and r_addr=first_addr.
- dump_valid rises after E1 (latency 2 edges from start).
- With dump_ready held at 1, word k is accepted at edge E1+k for k=1..K. done is high for the cycle after E1+K, and busy is 0 in that same cycle.
- Back-pressure stalls the stream only. Data is never dropped or duplicated, and dump_data is stable while valid=1 and ready=0.
- Reset asserted mid-dump returns all state to reset values immediately (asynchronous). No done pulse is produced. A new start is accepted on the first edge after rst deasserts.
- A start arriving in the same cycle as done (IDLE reached) is accepted.

## Test plan
- Full sweep: preload reg[i]=i*3, first=0, last=31, ready=1.
  - Expect 32 words (addr i, data i*3) on consecutive cycles.
  - dump_valid first high 2 edges after start.
  - done pulses once and busy falls in the same cycle.
- Single word: first=last=7, reg[7]=0xDEADBEEF.
  - Expect exactly one word (7, 0xDEADBEEF), then done.
- Wrap: first=30, last=1.
  - Expect addrs 30, 31, 0, 1 in order, then done.
- Back-pressure: first=2, last=5, ready toggling 1,0,0,1,...
  - Every word is held stable while ready=0.
  - Exactly 4 words arrive, in order, with no duplicates.
- Concurrent write: during a sweep, write reg[10]=0x55 on the same edge that captures addr 10.
  - Stream shows the old reg[10].
  - A repeat dump shows 0x55.
- Mid-dump reset: assert rst after 3 words.
  - All outputs are 0 immediately and no done pulse occurs.
  - start is ignored while busy.
  - After release, a new dump first=0, last=0 completes normally.
